iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Multi-cycle, bit-serial shift unit; drop-in sequential alternative to the single-cycle barrel shifter for area-constrained CPU variants.
- Accepts an operand, shift amount and op code through a valid/ready request port.
- Shifts one bit position per clock.
- Returns the result through a valid/ready response port. Sits between the multi-cycle CPU execute stage and its writeback mux.

Parameters:
DATA_WIDTH, 32, operand/result width in bits
SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
A  input  DATA_WIDTH  operand to shift
B  input  SHAMT_WIDTH  shift amount, unsigned
Shiftop  input  2  00 SLL, 10 SRL, 11 SRA, 01 ROR (rotate right)
out_valid  output  1  Result valid
out_ready  input  1  consumer accepts Result
Result  output  DATA_WIDTH  shifted value

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
- On rst_n=0, immediately and regardless of clk: state=IDLE, in_ready=1, out_valid=0, Result=0, internal count=0, latched op=00.
- Reset mid-operation aborts the operation. No result is ever presented for the aborted request.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch A into the working register, B into count and Shiftop into op. If B==0, go to DONE, else go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, apply one 1-bit step to the working register and decrement count. When count==1 on the current cycle, go to DONE after this step.
  - DONE: out_valid=1, in_ready=0. On out_ready=1, go to IDLE. Otherwise hold.
- In DONE, Result and out_valid must stay stable until the handshake completes.
- 1-bit step per op:
  - SLL: {w[DW-2:0],1'b0}
  - SRL: {1'b0,w[DW-1:1]}
  - SRA: {w[DW-1],w[DW-1:1]} (sign replicated from current MSB)
  - ROR: {w[0],w[DW-1:1]}
- Result is driven directly from the working register. Its value is defined only while out_valid=1; during SHIFT it shows intermediate values.
- Latency, measured from the accepting clock edge (edge 0): out_valid rises after edge max(B,1) when B==0, and after edge B+1 otherwise.
  - B=0 gives a result 1 cycle after accept.
  - B=31 gives a result 32 cycles after accept.
- Throughput: one request in flight. No new request is accepted in the same cycle as the out_valid/out_ready handshake. in_ready rises the cycle after that handshake.
- A, B and Shiftop are sampled only at the accept edge. Later changes on them have no effect.
- in_valid while in_ready=0 is ignored. The requester must hold in_valid until the handshake.
- Shift amount is the full B range 0..2^SHAMT_WIDTH-1. There is no modulo beyond the port width.
- out_ready asserted before out_valid has no effect. It is not remembered.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> out_valid=0, in_ready=1, Result=0 immediately, before the next clk edge.
- SRA: A=0x80000000, B=4, Shiftop=11, out_ready=1 -> Result=0xF8000000; out_valid first high 5 cycles after accept, high for exactly 1 cycle. Same stimulus with Shiftop=10 (SRL) -> 0x08000000.
- SLL max amount: A=0x00000001, B=31, Shiftop=00 -> Result=0x80000000 after 32 cycles; in_ready=0 throughout. Then ROR: A=0x00000001, B=1, Shiftop=01 -> 0x80000000 in 2 cycles.
- Zero shift and backpressure: A=0x12345678, B=0, op SRA, out_ready=0 for 10 cycles -> out_valid after 1 cycle. Result holds 0x12345678 and out_valid stays 1 for all 10 cycles. out_ready=1 -> IDLE next cycle. A new in_valid during the hold is not accepted.
- Abort: accept A=0xFFFF0000, B=20, SRL; pulse rst_n low at cycle 7 -> out_valid never rises for that request. The next request A=0x0000000F, B=2, SLL -> Result=0x0000003C.
- Back-to-back random: 1000 requests with random A, B and op, plus random in_valid/out_ready gaps -> every Result matches the golden barrel-shift/rotate model, in order, with none lost or duplicated.

Source files
------------

// File: rtl/iter_shifter.sv
// Bit-serial shifter: one bit position per clock, valid/ready on both sides.
// Sequential stand-in for the single-cycle barrel shifter.
module iter_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [SHAMT_WIDTH-1:0] B,
    input  logic [1:0]             Shiftop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  Result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q, work_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  step;

    always_comb begin
        step = work_q;
        unique case (op_q)
            2'b00: step = {work_q[DATA_WIDTH-2:0], 1'b0};
            2'b10: step = {1'b0, work_q[DATA_WIDTH-1:1]};
            2'b11: step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
            2'b01: step = {work_q[0], work_q[DATA_WIDTH-1:1]};
            default: step = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = A;
                    cnt_d   = B;
                    op_d    = Shiftop;
                    state_d = (B == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        // out_valid trails DONE entry by one cycle and drops on handshake
        out_valid_d = (state_q == DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Result    = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed and random checks of iter_shifter against a barrel-shift model.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [4:0]  B = '0;
    logic [1:0]  Shiftop = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Result;

    int passed = 0;
    int total  = 0;
    int pushed = 0;
    int popped = 0;
    logic [31:0] exp_q[$];
    bit rand_done = 1'b0;

    iter_shifter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Shiftop(Shiftop),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [31:0] a, logic [4:0] b,
                                          logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00: r = a << b;
            2'b10: r = a >> b;
            2'b11: r = 32'($signed(a) >>> b);
            default: r = (b == 0) ? a : ((a >> b) | (a << (6'd32 - {1'b0, b})));
        endcase
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: push on accept, pop on result handshake
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(A, B, Shiftop));
            pushed++;
        end
        if (rst_n && out_valid && out_ready) begin
            popped++;
            if (exp_q.size() == 0) check("extra_result", Result, 32'hx);
            else check("result", Result, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [31:0] a, logic [4:0] b, logic [1:0] op);
        int n;
        A = a; B = b; Shiftop = op; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("accept_timeout", 32'(n), 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic observe(int cycles, output int first, output int cnt,
                           output int rdy);
        first = -1; cnt = 0; rdy = 0;
        for (int k = 0; k <= cycles; k++) begin
            if (k > 0) tick();
            if (out_valid) begin
                if (first < 0) first = k;
                cnt++;
            end
            if (in_ready && (first < 0 || k <= first)) rdy++;
        end
    endtask

    initial begin
        int first, cnt, rdy, hv, hr, hd;
        int p0, q0, n;

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", Result, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        out_ready = 1'b1;
        issue(32'h8000_0000, 5'd4, 2'b11);
        observe(8, first, cnt, rdy);
        check("sra_latency", 32'(first), 32'd5);
        check("sra_valid_len", 32'(cnt), 32'd1);

        issue(32'h8000_0000, 5'd4, 2'b10);
        observe(8, first, cnt, rdy);
        check("srl_latency", 32'(first), 32'd5);

        issue(32'h0000_0001, 5'd31, 2'b00);
        observe(34, first, cnt, rdy);
        check("sll31_latency", 32'(first), 32'd32);
        check("sll31_in_ready_low", 32'(rdy), 32'd0);

        issue(32'h0000_0001, 5'd1, 2'b01);
        observe(4, first, cnt, rdy);
        check("ror1_latency", 32'(first), 32'd2);

        out_ready = 1'b0;
        issue(32'h1234_5678, 5'd0, 2'b11);
        check("b0_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("b0_latency", 32'(out_valid), 32'd1);
        A = 32'hDEAD_BEEF; B = 5'd3; Shiftop = 2'b00; in_valid = 1'b1;
        hv = 0; hr = 0; hd = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) hv++;
            if (Result == 32'h1234_5678) hd++;
            if (in_ready) hr++;
        end
        check("hold_valid", 32'(hv), 32'd10);
        check("hold_result", 32'(hd), 32'd10);
        check("hold_in_ready", 32'(hr), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("after_hs_valid", 32'(out_valid), 32'd0);
        check("after_hs_ready", 32'(in_ready), 32'd1);

        issue(32'hFFFF_0000, 5'd20, 2'b10);
        for (int k = 0; k < 6; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", Result, 32'd0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("abort_no_result", 32'(cnt), 32'd0);
        issue(32'h0000_000F, 5'd2, 2'b00);
        observe(5, first, cnt, rdy);
        check("post_abort_latency", 32'(first), 32'd3);

        p0 = pushed; q0 = popped;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    issue($urandom, 5'($urandom_range(0, 31)),
                          2'($urandom_range(0, 3)));
                end
                n = 0;
                while (exp_q.size() != 0 && n < 2000) begin
                    tick();
                    n++;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_pushed", 32'(pushed - p0), 32'd1000);
        check("rand_popped", 32'(popped - q0), 32'd1000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
